// File: rtl/r3_sdf_bf.sv
// Radix-3 single-delay-feedback butterfly stage: 3-point DFT over samples spaced D apart,
// emitted in SDF order (y0, y1, y2). Define R3_ROUND_EN for round-half-up on h and m.
module r3_sdf_bf #(
  parameter int DW = 8,
  parameter int D  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_valid,
  output logic signed [DW+1:0] out_re,
  output logic signed [DW+1:0] out_im,
  output logic                 out_valid,
  output logic [1:0]           out_idx
);

  localparam int OW = DW + 2;
  localparam int PW = OW + 10;
  localparam int CW = $clog2(3 * D);

  localparam logic [CW-1:0] CNT_LAST = CW'(3 * D - 1);
  localparam logic [CW-1:0] PH1_BASE = CW'(D);
  localparam logic [CW-1:0] PH2_BASE = CW'(2 * D);

  localparam logic signed [PW-1:0] M_K = PW'(222);
`ifdef R3_ROUND_EN
  localparam logic signed [PW-1:0] H_RND = PW'(1);
  localparam logic signed [PW-1:0] M_RND = PW'(128);
`else
  localparam logic signed [PW-1:0] H_RND = '0;
  localparam logic signed [PW-1:0] M_RND = '0;
`endif

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  logic [CW-1:0] cnt;
  logic          primed;
  phase_t        phase;

  logic signed [OW-1:0] f0_re [D];
  logic signed [OW-1:0] f0_im [D];
  logic signed [OW-1:0] f1_re [D];
  logic signed [OW-1:0] f1_im [D];

  logic signed [OW-1:0] in_x_re, in_x_im;
  logic signed [OW-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im;
  logic signed [OW-1:0] cand_re, cand_im;
  logic [1:0]           cand_idx;
  logic                 emit;

  function automatic logic signed [PW-1:0] wide(input logic signed [OW-1:0] v);
    return {{(PW - OW){v[OW-1]}}, v};
  endfunction

  always_comb begin
    if (cnt < PH1_BASE) begin
      phase = PH0;
    end else if (cnt < PH2_BASE) begin
      phase = PH1;
    end else begin
      phase = PH2;
    end
  end

  assign in_x_re = OW'(in_re);
  assign in_x_im = OW'(in_im);

  // In phase 2 both FIFO heads hold the raw x0/x1 pushed D samples earlier.
  always_comb begin
    logic signed [PW-1:0] a0r, a0i, a1r, a1i, a2r, a2i;
    logic signed [PW-1:0] hr, hi, pr, pi, mr, mi;
    a0r = wide(f0_re[D-1]);
    a0i = wide(f0_im[D-1]);
    a1r = wide(f1_re[D-1]);
    a1i = wide(f1_im[D-1]);
    a2r = wide(in_x_re);
    a2i = wide(in_x_im);
    hr  = (a1r + a2r + H_RND) >>> 1;
    hi  = (a1i + a2i + H_RND) >>> 1;
    pr  = M_K * (a1r - a2r) + M_RND;
    pi  = M_K * (a1i - a2i) + M_RND;
    mr  = pr >>> 8;
    mi  = pi >>> 8;
    y0_re = OW'(a0r + a1r + a2r);
    y0_im = OW'(a0i + a1i + a2i);
    y1_re = OW'(a0r - hr + mi);
    y1_im = OW'(a0i - hi - mr);
    y2_re = OW'(a0r - hr - mi);
    y2_im = OW'(a0i - hi + mr);
  end

  always_comb begin
    cand_re  = y0_re;
    cand_im  = y0_im;
    cand_idx = 2'd0;
    case (phase)
      PH0: begin
        cand_re  = f0_re[D-1];
        cand_im  = f0_im[D-1];
        cand_idx = 2'd1;
      end
      PH1: begin
        cand_re  = f1_re[D-1];
        cand_im  = f1_im[D-1];
        cand_idx = 2'd2;
      end
      default: begin
        cand_re  = y0_re;
        cand_im  = y0_im;
        cand_idx = 2'd0;
      end
    endcase
  end

  // Before the first complete group the FIFO heads are stale, so only y0 may leave.
  assign emit = (phase == PH2) || primed;

  // Feedback delay lines; contents are unobservable until primed, so no reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      if (phase != PH1) begin
        for (int i = D - 1; i > 0; i--) begin
          f0_re[i] <= f0_re[i-1];
          f0_im[i] <= f0_im[i-1];
        end
        f0_re[0] <= (phase == PH2) ? y1_re : in_x_re;
        f0_im[0] <= (phase == PH2) ? y1_im : in_x_im;
      end
      if (phase != PH0) begin
        for (int i = D - 1; i > 0; i--) begin
          f1_re[i] <= f1_re[i-1];
          f1_im[i] <= f1_im[i-1];
        end
        f1_re[0] <= (phase == PH2) ? y2_re : in_x_re;
        f1_im[0] <= (phase == PH2) ? y2_im : in_x_im;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_valid <= 1'b0;
      out_idx   <= 2'd0;
    end else begin
      out_valid <= in_valid && emit;
      if (in_valid) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          primed <= 1'b1;
        end
        if (emit) begin
          out_re  <= cand_re;
          out_im  <= cand_im;
          out_idx <= cand_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_r3_sdf_bf.sv
// Directed scoreboard bench for r3_sdf_bf (DW=8, D=3); expectations follow R3_ROUND_EN.
module tb_r3_sdf_bf;

  localparam int DW = 8;
  localparam int D  = 3;
  localparam int OW = DW + 2;
  localparam int EW = 2 + 2 * OW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 in_valid = 1'b0;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic                 out_valid;
  logic [1:0]           out_idx;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0]        exp_q[$];
  logic [EW-1:0]        last_exp = '0;
  logic [EW-1:0]        popped;
  logic                 sampled_v = 1'b0;
  logic signed [DW-1:0] s_re[$];
  logic signed [DW-1:0] s_im[$];

  r3_sdf_bf #(.DW(DW), .D(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_re(in_re),
    .in_im(in_im),
    .in_valid(in_valid),
    .out_re(out_re),
    .out_im(out_im),
    .out_valid(out_valid),
    .out_idx(out_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input int idx, input int re, input int im);
    logic [31:0] a, b, c;
    a = idx;
    b = re;
    c = im;
    return {a[1:0], b[OW-1:0], c[OW-1:0]};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (idx|re|im)", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) sampled_v <= in_valid;

  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (!sampled_v) begin
      check("valid_low_after_gap", EW'(out_valid), '0);
      check("hold_in_gap", {out_idx, out_re, out_im}, last_exp);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: actual=%h required=none", {out_idx, out_re, out_im});
      end else begin
        popped = exp_q.pop_front();
        check("scoreboard", {out_idx, out_re, out_im}, popped);
        last_exp = popped;
      end
    end
  end

  // driver tasks; each returns at a falling edge
  task automatic exp3(input int idx, input int re, input int im);
    for (int i = 0; i < 3; i++) exp_q.push_back(pack(idx, re, im));
  endtask

  task automatic add_lanes(input int re, input int im, input int n);
    for (int i = 0; i < n; i++) begin
      s_re.push_back(DW'(re));
      s_im.push_back(DW'(im));
    end
  endtask

  task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  task automatic play(input bit stall, input int n);
    for (int i = 0; i < n; i++) begin
      if (stall) gap();
      send(s_re[i], s_im[i]);
    end
    s_re.delete();
    s_im.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    gap();
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    #1;
    check("reset_re", EW'(out_re), '0);
    check("reset_im", EW'(out_im), '0);
    check("reset_valid", EW'(out_valid), '0);
    check("reset_idx", EW'(out_idx), '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic basic_stim();
    add_lanes(10, 0, 3);
    add_lanes(20, 0, 3);
    add_lanes(30, 0, 3);
    add_lanes(0, 0, 6);
  endtask

  task automatic basic_exp();
    exp3(0, 60, 0);
    exp3(1, -15, 9);
    exp3(2, -15, -9);
  endtask

  task automatic mixed_exp();
`ifdef R3_ROUND_EN
    exp3(0, 8, 8);
    exp3(1, -3, -19);
    exp3(2, 9, 1);
`else
    exp3(0, 8, 8);
    exp3(1, -3, -17);
    exp3(2, 11, 1);
`endif
  endtask

  initial begin
    do_reset();

    // basic group
    basic_exp();
    basic_stim();
    play(1'b0, 15);
    drain();
    do_reset();

    // impulse on the first lane only
    exp_q.push_back(pack(0, 1, 0));
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(0, 0, 0));
    exp_q.push_back(pack(1, 1, 0));
    exp_q.push_back(pack(1, 0, 0));
    exp_q.push_back(pack(1, 0, 0));
    exp_q.push_back(pack(2, 1, 0));
    exp_q.push_back(pack(2, 0, 0));
    exp_q.push_back(pack(2, 0, 0));
    add_lanes(1, 0, 1);
    add_lanes(0, 0, 14);
    play(1'b0, 15);
    drain();
    do_reset();

    // extremes
    exp3(0, -384, -384);
    exp3(1, 0, 0);
    exp3(2, 0, 0);
    add_lanes(-128, -128, 9);
    add_lanes(0, 0, 6);
    play(1'b0, 15);
    drain();
    do_reset();

    // complex operands exercising both m components
    mixed_exp();
    add_lanes(5, -3, 3);
    add_lanes(7, 2, 3);
    add_lanes(-4, 9, 3);
    add_lanes(0, 0, 6);
    play(1'b0, 15);
    drain();
    do_reset();

    // stalls every other cycle
    basic_exp();
    basic_stim();
    play(1'b1, 15);
    drain();
    do_reset();

    // reset mid-frame after the 5th input, then restart
    add_lanes(10, 0, 3);
    add_lanes(20, 0, 2);
    play(1'b0, 5);
    do_reset();
    basic_exp();
    basic_stim();
    play(1'b0, 15);
    drain();
    do_reset();

    // back-to-back groups with no gap between them
    exp3(0, 60, 0);
    exp3(1, -15, 9);
    exp3(2, -15, -9);
    mixed_exp();
    add_lanes(10, 0, 3);
    add_lanes(20, 0, 3);
    add_lanes(30, 0, 3);
    add_lanes(5, -3, 3);
    add_lanes(7, 2, 3);
    add_lanes(-4, 9, 3);
    add_lanes(0, 0, 6);
    play(1'b0, 24);
    drain();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
